// File: rtl/fifo_cpu_pkg.sv
// rtl/fifo_cpu_pkg.sv - shared constants and types for the FIFO CPU register slave
package fifo_cpu_pkg;

   // Register addresses
   localparam logic [3:0] ADDR_CTRL     = 4'h0;
   localparam logic [3:0] ADDR_AF       = 4'h1;
   localparam logic [3:0] ADDR_AE       = 4'h2;
   localparam logic [3:0] ADDR_STATUS   = 4'h3;
   localparam logic [3:0] ADDR_LEVEL    = 4'h4;
   localparam logic [3:0] ADDR_INT_STAT = 4'h5;
   localparam logic [3:0] ADDR_INT_MASK = 4'h6;
   localparam logic [3:0] ADDR_ID       = 4'h7;

   // Bit positions inside CTRL and the interrupt registers
   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_FLUSH_BIT = 1;
   localparam int INT_OVF_BIT    = 0;
   localparam int INT_UDF_BIT    = 1;

   // Bus access sequencer states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      WAIT_REL = 2'd2
   } bus_state_t;

   // Reset values
   localparam logic [7:0] DATAOUT_RESET = 8'h00;
   localparam logic [1:0] INT_RESET     = 2'b00;
   localparam logic [7:0] AF_DEFAULT    = 8'd12;
   localparam logic [7:0] AE_DEFAULT    = 8'd4;
   localparam logic [7:0] ID_DEFAULT    = 8'hA5;

endpackage

// File: rtl/cdc_sync_bit.sv
// rtl/cdc_sync_bit.sv - multi-flop synchroniser for a single asynchronous bit
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;

   // Shift the asynchronous input through the flop chain
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/fifo_cpu_regs.sv
// rtl/fifo_cpu_regs.sv - CPU local-bus register slave for FIFO configuration and status
module fifo_cpu_regs
   import fifo_cpu_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] ID_VALUE    = ID_DEFAULT,
   parameter logic [7:0] AF_RESET    = AF_DEFAULT,
   parameter logic [7:0] AE_RESET    = AE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       CS,
   input  logic       Rd_Wr,
   input  logic [3:0] Addr,
   input  logic [7:0] DataIn,
   output logic [7:0] DataOut,
   output logic       fifo_en,
   output logic       fifo_flush,
   output logic [7:0] af_thresh,
   output logic [7:0] ae_thresh,
   input  logic       fifo_empty,
   input  logic       fifo_full,
   input  logic       fifo_aempty,
   input  logic       fifo_afull,
   input  logic [7:0] fifo_level,
   input  logic       ovf_evt,
   input  logic       udf_evt,
   output logic       irq
);

   // After reset the synchroniser holds zeros, not real CS samples; WAIT_REL must not
   // trust cs_s until the chain has been refilled, or CS held across reset would fire.
   localparam int              SW         = $clog2(SYNC_STAGES + 1);
   localparam logic [SW-1:0]   SETTLE_MAX = SW'(SYNC_STAGES);

   logic          cs_s;
   bus_state_t    state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          settled;
   logic          wr_en, rd_en;
   logic [7:0]    rdata;
   logic [7:0]    data_out_q, data_out_d;
   logic          fifo_en_q, fifo_en_d;
   logic          flush_q, flush_d;
   logic [7:0]    af_q, af_d;
   logic [7:0]    ae_q, ae_d;
   logic [1:0]    stat_q, stat_d;
   logic [1:0]    mask_q, mask_d;
   logic [1:0]    stat_clr;
   logic          irq_q, irq_d;

   cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk (clk),
      .rst (rst),
      .d_i (CS),
      .q_o (cs_s)
   );

   assign settled = (settle_q == SETTLE_MAX);

   // Next-state logic: one access per synchronised CS assertion
   always_comb begin
      state_d  = state_q;
      settle_d = settled ? settle_q : settle_q + 1'b1;
      unique case (state_q)
         IDLE:     if (cs_s) state_d = ACCESS;
         ACCESS:   state_d = WAIT_REL;
         WAIT_REL: if (settled && !cs_s) state_d = IDLE;
         default:  state_d = WAIT_REL;
      endcase
   end

   assign wr_en = (state_q == ACCESS) && !Rd_Wr;
   assign rd_en = (state_q == ACCESS) &&  Rd_Wr;

   // Read multiplexer; unmapped addresses return zero
   always_comb begin
      rdata = 8'h00;
      unique case (Addr)
         ADDR_CTRL:     rdata = {7'b0, fifo_en_q};
         ADDR_AF:       rdata = af_q;
         ADDR_AE:       rdata = ae_q;
         ADDR_STATUS:   rdata = {4'b0, fifo_afull, fifo_aempty, fifo_full, fifo_empty};
         ADDR_LEVEL:    rdata = fifo_level;
         ADDR_INT_STAT: rdata = {6'b0, stat_q};
         ADDR_INT_MASK: rdata = {6'b0, mask_q};
         ADDR_ID:       rdata = ID_VALUE;
         default:       rdata = 8'h00;
      endcase
   end

   // Register file update; event set takes priority over a W1C clear of the same bit
   always_comb begin
      data_out_d = rd_en ? rdata : data_out_q;
      fifo_en_d  = fifo_en_q;
      flush_d    = 1'b0;
      af_d       = af_q;
      ae_d       = ae_q;
      mask_d     = mask_q;
      stat_clr   = 2'b00;
      if (wr_en) begin
         unique case (Addr)
            ADDR_CTRL: begin
               fifo_en_d = DataIn[CTRL_EN_BIT];
               flush_d   = DataIn[CTRL_FLUSH_BIT];
            end
            ADDR_AF:       af_d     = DataIn;
            ADDR_AE:       ae_d     = DataIn;
            ADDR_INT_STAT: stat_clr = DataIn[1:0];
            ADDR_INT_MASK: mask_d   = DataIn[1:0];
            default: ;
         endcase
      end
      stat_d              = stat_q & ~stat_clr;
      stat_d[INT_OVF_BIT] = stat_d[INT_OVF_BIT] | ovf_evt;
      stat_d[INT_UDF_BIT] = stat_d[INT_UDF_BIT] | udf_evt;
      irq_d               = |(stat_q & mask_q);
   end

   // State and register flops with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WAIT_REL;
         settle_q   <= '0;
         data_out_q <= DATAOUT_RESET;
         fifo_en_q  <= 1'b0;
         flush_q    <= 1'b0;
         af_q       <= AF_RESET;
         ae_q       <= AE_RESET;
         stat_q     <= INT_RESET;
         mask_q     <= INT_RESET;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         data_out_q <= data_out_d;
         fifo_en_q  <= fifo_en_d;
         flush_q    <= flush_d;
         af_q       <= af_d;
         ae_q       <= ae_d;
         stat_q     <= stat_d;
         mask_q     <= mask_d;
         irq_q      <= irq_d;
      end
   end

   assign DataOut    = data_out_q;
   assign fifo_en    = fifo_en_q;
   assign fifo_flush = flush_q;
   assign af_thresh  = af_q;
   assign ae_thresh  = ae_q;
   assign irq        = irq_q;

endmodule
